// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: prefix bytes, codes the byte
// layer discards, and the frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Controller responses (BAT pass, echo, ack, resend, errors), not key events.
  localparam int PS2_NUM_IGNORED = 6;
  localparam logic [7:0] PS2_IGNORED [PS2_NUM_IGNORED] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  function automatic logic is_ignored(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_IGNORED; i++) begin
      if (code == PS2_IGNORED[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// falling-edge strobe, 11-bit frame FSM with odd-parity/stop check and timeout.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | bus idle, waiting for a start bit (data=0)
//   ST_SHIFT  | receiving 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking stop bit and parity, then back to idle
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       err
);
  import ps2_pkg::*;

  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          strobe;

  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] tmo_cnt;

  assign rx_byte = shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock only follows the pin after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      flt_cnt <= '0;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
        strobe  <= ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
      byte_ok <= 1'b0;
      err     <= 1'b0;
    end else begin
      byte_ok <= 1'b0;
      err     <= 1'b0;
      if (strobe) begin
        tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_SHIFT;
              bit_cnt <= '0;
            end
          end
          ST_SHIFT: begin
            shift <= {data_s2, shift[7:1]};
            if (bit_cnt == 3'd7) state <= ST_PARITY;
            else bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: begin
            par   <= data_s2;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (data_s2 && (^{shift, par})) byte_ok <= 1'b1;
            else err <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == '0) begin
          state <= ST_IDLE;
          err   <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: frame reception plus the prefix/byte layer that
// turns E0/F0 sequences into make/break events and tracks the held key.
module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_held,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] rx_byte;
  logic       byte_ok;
  logic       rx_err;
  logic       ext_flag;
  logic       brk_flag;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .byte_ok (byte_ok),
    .err     (rx_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      key_break <= 1'b0;
      key_held  <= 1'b0;
      frame_err <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_break <= 1'b0;
      frame_err <= 1'b0;
      if (rx_err) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (byte_ok) begin
        if (rx_byte == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!is_ignored(rx_byte)) begin
            key_code <= rx_byte;
            key_ext  <= ext_flag;
            if (brk_flag) begin
              key_break <= 1'b1;
              // Releasing some other key must not drop the held indication.
              if ({ext_flag, rx_byte} == {key_ext, key_code}) key_held <= 1'b0;
            end else begin
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
